fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller for the 8-bit byte-addressed program memory. Owns the program counter, drives the memory's combinational read address, and captures 32-bit little-endian instruction words into a small prefetch FIFO. Presents instructions to decode over a valid/ready handshake and accepts PC redirects from the branch unit. Sits between `program_memory` and the decode stage.

## Interface
Parameters:
- `RESET_PC`, 8'h00, PC loaded on reset
- `FIFO_DEPTH`, 2, prefetch entries (2 or 4 only)

Ports:
- `clk_i` input 1: single clock, all state updates on rising edge
- `rst_i` input 1: synchronous, active-high reset
- `start_i` input 1: leaves IDLE and begins fetching
- `imem_addr_o` output 8: byte address to program memory (combinational from PC register)
- `imem_data_i` input 32: instruction word from program memory, same-cycle combinational return
- `redirect_valid_i` input 1: load new PC this cycle
- `redirect_pc_i` input 8: redirect target byte address
- `instr_valid_o` output 1: FIFO head holds a valid instruction
- `instr_ready_i` input 1: decode accepts FIFO head
- `instr_o` output 32: FIFO head instruction word
- `instr_pc_o` output 8: byte address the head word was fetched from
- `fault_o` output 1: sticky misaligned-redirect fault

## Operation
- State machine: IDLE, FETCH, FAULT.
  - IDLE → FETCH when `start_i`=1 (and no fault-causing redirect that cycle).
  - FETCH stays until a fault; no return to IDLE except via reset.
  - Any state → FAULT when `redirect_valid_i`=1 and `redirect_pc_i[1:0]`≠0. FAULT exits only on `rst_i`.
- Registers: `pc` (8b), FIFO of `FIFO_DEPTH` × {pc[7:0], word[31:0]}, occupancy count.
- `imem_addr_o` = `pc` at all times.
- Pop: `instr_valid_o` && `instr_ready_i`.
- Push: state==FETCH && !`redirect_valid_i` && (count<FIFO_DEPTH || pop). Entry = {`pc`, `imem_data_i`}; `pc` <= `pc`+4, modulo 256 (252+4 → 0).
- Push and pop in the same cycle at full or non-empty: both occur, count unchanged.
- Aligned redirect (any state except FAULT): FIFO flushed (count ← 0), `pc` ← `redirect_pc_i`, no push that cycle, pop ignored. Redirect in IDLE updates `pc` without starting fetch.
- Misaligned redirect: FIFO flushed, `pc` unchanged, `fault_o` ← 1, state ← FAULT; no further pushes.
- `start_i` in FETCH or FAULT: ignored.
- Redirect has priority over push, pop and start.

## Timing
- Reset values: `pc`=RESET_PC, count=0, state=IDLE, `instr_valid_o`=0, `instr_o`=0, `instr_pc_o`=0, `fault_o`=0, `imem_addr_o`=RESET_PC.
- `rst_i` mid-operation: all of the above next edge, pending FIFO contents discarded, regardless of other inputs.
- Start latency: `start_i` at cycle N → FETCH at N+1, first push at N+1, `instr_valid_o`=1 at N+2.
- Push-to-output latency: 1 cycle (FIFO outputs registered; no combinational path from `imem_data_i` to `instr_o`).
- Redirect latency: `redirect_valid_i` at cycle N → `instr_valid_o`=0 at N+1, target word pushed at N+1, valid with `instr_pc_o`=target at N+2.
- Throughput: one instruction per cycle with `instr_ready_i` held high.
- `instr_o`/`instr_pc_o` stable while `instr_valid_o`=1 and `instr_ready_i`=0.
- `fault_o` asserts the cycle after the faulting redirect and holds until reset.

## Test plan
- Reset, `start_i` pulse at cycle 0, ready high, memory bytes 00..FF → valid from cycle 2, `instr_pc_o` 0x00,0x04,0x08…, `instr_o` 0x03020100, 0x07060504…
- Back-pressure: start, `instr_ready_i`=0 → FIFO fills with pc 0x00,0x04; `imem_addr_o` holds 0x08; raise ready → 0x00,0x04,0x08 delivered consecutively, no gaps or duplicates.
- Redirect to 0x40 while FIFO full → `instr_valid_o`=0 next cycle, then `instr_pc_o`=0x40, 0x44; old entries never appear.
- Wrap: redirect to 0xF8 → `instr_pc_o` sequence 0xF8, 0xFC, 0x00, 0x04.
- Redirect to 0x41 → `fault_o`=1 next cycle, `instr_valid_o`=0, `imem_addr_o` unchanged, further `start_i`/aligned redirects have no effect.
- Assert `rst_i` mid-stream and during FAULT → all outputs to reset values next cycle; `start_i` then restarts fetch from RESET_PC.

Source files
------------

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC owner and prefetch FIFO between
// program memory and decode, with redirect and fault handling.
module fetch_sequencer #(
  parameter logic [7:0] RESET_PC   = 8'h00,
  parameter int         FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic [7:0]  imem_addr_o,
  input  logic [31:0] imem_data_i,
  input  logic        redirect_valid_i,
  input  logic [7:0]  redirect_pc_i,
  output logic        instr_valid_o,
  input  logic        instr_ready_i,
  output logic [31:0] instr_o,
  output logic [7:0]  instr_pc_o,
  output logic        fault_o
);

  localparam int AW = (FIFO_DEPTH == 4) ? 2 : 1;
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    FAULT
  } state_t;

  state_t         state;
  logic [7:0]     pc;
  logic [AW:0]    count;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  wr_ptr;
  logic           fault_q;
  logic [31:0]    word_q [FIFO_DEPTH];
  logic [7:0]     pc_q   [FIFO_DEPTH];

  logic redir_ok;
  logic redir_bad;
  logic pop;
  logic push;

  // Redirect decode and FIFO handshake qualifiers
  always_comb begin
    redir_bad = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
    redir_ok  = redirect_valid_i && !redir_bad && (state != FAULT);
    pop       = instr_valid_o && instr_ready_i && !redirect_valid_i;
    push      = (state == FETCH) && !redirect_valid_i
                && ((count < FULL) || pop);
  end

  // Control state machine with sticky fault flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state   <= IDLE;
      fault_q <= 1'b0;
    end else if (redir_bad) begin
      state   <= FAULT;
      fault_q <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_i && !redirect_valid_i) state <= FETCH;
        end
        FETCH: state <= FETCH;
        FAULT: state <= FAULT;
        default: state <= IDLE;
      endcase
    end
  end

  // Program counter: redirect load or sequential advance on push
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc <= RESET_PC;
    end else if (redir_ok) begin
      pc <= redirect_pc_i;
    end else if (push) begin
      pc <= pc + 8'd4;
    end
  end

  // FIFO pointers and occupancy; any redirect flushes
  always_ff @(posedge clk_i) begin
    if (rst_i || redirect_valid_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are masked by the valid flag
  always_ff @(posedge clk_i) begin
    if (push) begin
      word_q[wr_ptr] <= imem_data_i;
      pc_q[wr_ptr]   <= pc;
    end
  end

  assign imem_addr_o   = pc;
  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? word_q[rd_ptr] : 32'h0;
  assign instr_pc_o    = instr_valid_o ? pc_q[rd_ptr] : 8'h00;
  assign fault_o       = fault_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench for fetch_sequencer
// with a byte-ramp program memory.
module tb_fetch_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [7:0]  imem_addr_o;
  logic [31:0] imem_data_i;
  logic        redirect_valid_i;
  logic [7:0]  redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [7:0]  instr_pc_o;
  logic        fault_o;

  int total = 0;
  int bad   = 0;

  fetch_sequencer #(
    .RESET_PC(8'h00),
    .FIFO_DEPTH(2)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .imem_addr_o(imem_addr_o),
    .imem_data_i(imem_data_i),
    .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i(redirect_pc_i),
    .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i),
    .instr_o(instr_o),
    .instr_pc_o(instr_pc_o),
    .fault_o(fault_o)
  );

  always #5 clk_i = ~clk_i;

  // memory byte at address a holds value a
  always_comb begin
    imem_data_i = {imem_addr_o + 8'd3, imem_addr_o + 8'd2,
                   imem_addr_o + 8'd1, imem_addr_o};
  end

  function automatic logic [31:0] word_at(input logic [7:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = a;
    b1 = a + 8'd1;
    b2 = a + 8'd2;
    b3 = a + 8'd3;
    return {b3, b2, b1, b0};
  endfunction

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    check({tag, " valid"}, 64'(instr_valid_o), 64'd0);
    check({tag, " instr"}, 64'(instr_o), 64'd0);
    check({tag, " ipc"},   64'(instr_pc_o), 64'd0);
    check({tag, " fault"}, 64'(fault_o), 64'd0);
    check({tag, " addr"},  64'(imem_addr_o), 64'h00);
  endtask

  task automatic chk_head(input string tag, input logic [7:0] a);
    check({tag, " valid"}, 64'(instr_valid_o), 64'd1);
    check({tag, " ipc"},   64'(instr_pc_o), 64'(a));
    check({tag, " instr"}, 64'(instr_o), 64'(word_at(a)));
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    start_i = 1'b0;
    redirect_valid_i = 1'b0;
    step();
    rst_i = 1'b0;
  endtask

  logic [7:0] exp_pc;

  initial begin
    rst_i = 1'b1;
    start_i = 1'b0;
    instr_ready_i = 1'b0;
    redirect_valid_i = 1'b0;
    redirect_pc_i = 8'h00;
    step();
    step();
    chk_reset("rst");

    // streaming with ready held high
    rst_i = 1'b0;
    start_i = 1'b1;
    instr_ready_i = 1'b1;
    step();
    start_i = 1'b0;
    check("st c1 valid", 64'(instr_valid_o), 64'd0);
    step();
    exp_pc = 8'h00;
    for (int i = 0; i < 5; i++) begin
      chk_head("stream", exp_pc);
      exp_pc = exp_pc + 8'd4;
      step();
    end

    // back-pressure fills the FIFO, then drains without gaps
    do_reset();
    chk_reset("rst2");
    start_i = 1'b1;
    instr_ready_i = 1'b0;
    step();
    start_i = 1'b0;
    for (int i = 0; i < 4; i++) step();
    chk_head("bp full", 8'h00);
    check("bp addr", 64'(imem_addr_o), 64'h08);
    instr_ready_i = 1'b1;
    exp_pc = 8'h04;
    for (int i = 0; i < 3; i++) begin
      step();
      chk_head("bp drain", exp_pc);
      exp_pc = exp_pc + 8'd4;
    end

    // redirect while full
    instr_ready_i = 1'b0;
    step();
    step();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 8'h40;
    step();
    redirect_valid_i = 1'b0;
    check("rd valid0", 64'(instr_valid_o), 64'd0);
    check("rd addr", 64'(imem_addr_o), 64'h40);
    step();
    chk_head("rd tgt", 8'h40);
    instr_ready_i = 1'b1;
    step();
    chk_head("rd next", 8'h44);

    // wrap around the top of memory
    redirect_valid_i = 1'b1;
    redirect_pc_i = 8'hF8;
    step();
    redirect_valid_i = 1'b0;
    check("wr valid0", 64'(instr_valid_o), 64'd0);
    step();
    chk_head("wrap", 8'hF8);
    step();
    chk_head("wrap", 8'hFC);
    step();
    chk_head("wrap", 8'h00);
    step();
    chk_head("wrap", 8'h04);
    check("wr addr", 64'(imem_addr_o), 64'h08);

    // misaligned redirect faults and locks up
    redirect_valid_i = 1'b1;
    redirect_pc_i = 8'h41;
    step();
    redirect_valid_i = 1'b0;
    check("flt fault", 64'(fault_o), 64'd1);
    check("flt valid", 64'(instr_valid_o), 64'd0);
    check("flt addr", 64'(imem_addr_o), 64'h08);
    start_i = 1'b1;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 8'h20;
    step();
    start_i = 1'b0;
    redirect_valid_i = 1'b0;
    step();
    check("flt hold", 64'(fault_o), 64'd1);
    check("flt nv", 64'(instr_valid_o), 64'd0);
    check("flt addr2", 64'(imem_addr_o), 64'h08);

    // reset out of FAULT, then restart
    rst_i = 1'b1;
    start_i = 1'b1;
    step();
    chk_reset("rst flt");
    rst_i = 1'b0;
    step();
    start_i = 1'b0;
    step();
    chk_head("restart", 8'h00);
    step();
    chk_head("restart", 8'h04);

    // reset mid-stream
    rst_i = 1'b1;
    step();
    chk_reset("rst mid");
    rst_i = 1'b0;

    // redirect in IDLE moves pc but does not start
    redirect_valid_i = 1'b1;
    redirect_pc_i = 8'h80;
    step();
    redirect_valid_i = 1'b0;
    check("idle addr", 64'(imem_addr_o), 64'h80);
    step();
    check("idle nv", 64'(instr_valid_o), 64'd0);
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    chk_head("idle go", 8'h80);

    // misaligned redirect in IDLE also faults
    redirect_valid_i = 1'b1;
    redirect_pc_i = 8'h02;
    step();
    redirect_valid_i = 1'b0;
    check("idle flt", 64'(fault_o), 64'd1);
    check("idle fnv", 64'(instr_valid_o), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
